// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch front end: debounce timing defaults,
// channel numbering and the arbitration helper used by button_conditioner.
package stopwatch_pkg;

    // 10 ms of stable input at a 100 MHz system clock.
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;
    // 2^20 = 1048576 covers the default debounce interval.
    localparam int CNT_W_DEF           = 20;
    // Short interval used in simulation so presses resolve in a few cycles.
    localparam int DEBOUNCE_SIM        = 4;

    // Channel indices into the per-channel raw and conditioned vectors.
    localparam int CH_START     = 0;
    localparam int CH_STOP      = 1;
    localparam int CH_RESET     = 2;
    localparam int CH_LAP       = 3;
    localparam int CH_COUNTDOWN = 4;
    localparam int NUM_CH       = 5;

    // One conditioned value per channel, in output order.
    typedef struct packed {
        logic start;
        logic stop;
        logic reset_button;
        logic lap_button;
        logic count_down;
    } cond_t;

    // Priority among the stopwatch commands: reset beats start and stop,
    // stop beats start. Lap and the direction level pass untouched.
    function automatic cond_t arbitrate(input cond_t req);
        cond_t grant;
        grant              = req;
        grant.stop         = req.stop  && !req.reset_button;
        grant.start        = req.start && !req.stop && !req.reset_button;
        return grant;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Raw pushbutton/switch inputs and conditioned outputs of the stopwatch
// front end. The board side drives the raw levels (master); the
// conditioner reads them and drives the clean pulses and level (slave).
interface button_conditioner_if;

    logic startRaw;
    logic stopRaw;
    logic resetRaw;
    logic lapRaw;
    logic countDownRaw;

    logic start;
    logic stop;
    logic resetButton;
    logic lapButton;
    logic countDown;

    modport master (
        output startRaw, stopRaw, resetRaw, lapRaw, countDownRaw,
        input  start, stop, resetButton, lapButton, countDown
    );

    modport slave (
        input  startRaw, stopRaw, resetRaw, lapRaw, countDownRaw,
        output start, stop, resetButton, lapButton, countDown
    );

endinterface

// File: rtl/button_conditioner_debounce_channel.sv
// One debounce channel: two-flop synchronizer, stability counter, stable
// level and rise detect. cond_nxt is the value the output register should
// load at the coming edge: the rise pulse for button channels, or the next
// stable level for level channels.
module debounce_channel
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF,
    parameter bit PULSE           = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic cond_nxt
);

    // Last count value before the stable level is allowed to follow.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    logic             differ;
    logic             expire;
    logic             stable_nxt;
    logic             rise;

    // Decide whether the synchronized value has held long enough to be accepted.
    // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
    always_comb begin
        differ     = (sync2 != stable);
        expire     = differ && (cnt == CNT_MAX);
        stable_nxt = expire ? sync2 : stable;
        rise       = expire && sync2;
        cond_nxt   = PULSE ? rise : stable_nxt;
    end

    // Synchronize the raw input and track how long it has disagreed with stable.
    // NOTE: non-blocking assignments let sync2 take the old sync1, forming a real two-flop chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            stable <= stable_nxt;
            // Agreement or acceptance both restart the count, so it never
            // climbs past CNT_MAX and cannot wrap.
            if (!differ || expire) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Stopwatch button front end: debounces four pushbuttons and one slide
// switch, turns button presses into single-cycle pulses, resolves
// conflicting commands and presents everything from output flops.
module button_conditioner
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    button_conditioner_if.slave  btn
);

    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] cond_nxt;

    cond_t req;
    cond_t grant;
    cond_t out_q;

    assign raw[CH_START]     = btn.startRaw;
    assign raw[CH_STOP]      = btn.stopRaw;
    assign raw[CH_RESET]     = btn.resetRaw;
    assign raw[CH_LAP]       = btn.lapRaw;
    assign raw[CH_COUNTDOWN] = btn.countDownRaw;

    // Buttons produce press pulses; the direction switch produces a level.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .PULSE           (i != CH_COUNTDOWN)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .raw      (raw[i]),
            .cond_nxt (cond_nxt[i])
        );
    end

    // Collect the channel results and resolve conflicting commands before registering.
    always_comb begin
        req = '{
            start:        cond_nxt[CH_START],
            stop:         cond_nxt[CH_STOP],
            reset_button: cond_nxt[CH_RESET],
            lap_button:   cond_nxt[CH_LAP],
            count_down:   cond_nxt[CH_COUNTDOWN]
        };
        grant = arbitrate(req);
    end

    // Output register: every output is a flop, aligned with its stable-level change.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
        end else begin
            out_q <= grant;
        end
    end

    assign btn.start       = out_q.start;
    assign btn.stop        = out_q.stop;
    assign btn.resetButton = out_q.reset_button;
    assign btn.lapButton   = out_q.lap_button;
    assign btn.countDown   = out_q.count_down;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a 4-cycle debounce interval.
// Inputs change on the falling edge; outputs are checked on the falling
// edge after each rising edge. Vectors are {start, stop, resetButton,
// lapButton, countDown}; raw vectors use the same bit order.
module tb_button_conditioner;
    import stopwatch_pkg::*;

    localparam int DC = DEBOUNCE_SIM;
    localparam int CW = 3;

    localparam logic [4:0] O_START = 5'b10000;
    localparam logic [4:0] O_STOP  = 5'b01000;
    localparam logic [4:0] O_RST   = 5'b00100;
    localparam logic [4:0] O_LAP   = 5'b00010;
    localparam logic [4:0] O_CD    = 5'b00001;
    localparam logic [4:0] O_NONE  = 5'b00000;

    logic clk = 1'b0;
    logic reset;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    button_conditioner_if bif ();

    button_conditioner #(
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btn   (bif)
    );

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {bif.start, bif.stop, bif.resetButton, bif.lapButton, bif.countDown};
    endfunction

    task automatic set_raw(input logic [4:0] v);
        {bif.startRaw, bif.stopRaw, bif.resetRaw, bif.lapRaw, bif.countDownRaw} = v;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hold raw at v for n edges; exactly one pulse vector p at edge 6 (0 = none).
    task automatic run(input string tag, input logic [4:0] v, input int n,
                       input logic [4:0] p, input logic [4:0] lvl_from6);
        logic [4:0] exp;
        set_raw(v);
        for (int e = 1; e <= n; e++) begin
            step();
            exp = (e == 6) ? p : O_NONE;
            if (e >= 6) exp = exp | lvl_from6;
            check($sformatf("%s e%0d", tag, e), outs(), exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected self-termination");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] exp;

        reset = 1'b1;
        set_raw(O_NONE);
        @(negedge clk);

        // Reset state
        for (int e = 1; e <= 3; e++) begin
            step();
            check($sformatf("reset e%0d", e), outs(), O_NONE);
        end
        reset = 1'b0;
        run("idle", O_NONE, 4, O_NONE, O_NONE);

        // Clean press: pulse only at edge 6, nothing while held or on release
        run("press",   O_START, 20, O_START, O_NONE);
        run("release", O_NONE,  12, O_NONE,  O_NONE);

        // Bounce on lap: 2 high, 2 low, repeated for 12 cycles
        for (int k = 0; k < 12; k++) begin
            set_raw(((k / 2) % 2 == 0) ? O_LAP : O_NONE);
            step();
            check($sformatf("bounce k%0d", k), outs(), O_NONE);
        end
        run("lap_hold", O_LAP,  12, O_LAP,  O_NONE);
        run("lap_rel",  O_NONE, 12, O_NONE, O_NONE);

        // Glitch of 3 cycles: rejected
        for (int e = 1; e <= 14; e++) begin
            set_raw((e <= 3) ? O_STOP : O_NONE);
            step();
            check($sformatf("glitch3 e%0d", e), outs(), O_NONE);
        end
        // Exactly DEBOUNCE_CYCLES high: accepted, single pulse at edge 6
        for (int e = 1; e <= 16; e++) begin
            set_raw((e <= 4) ? O_STOP : O_NONE);
            step();
            exp = (e == 6) ? O_STOP : O_NONE;
            check($sformatf("pulse4 e%0d", e), outs(), exp);
        end

        // Collisions: reset beats start/stop, lap always passes
        run("coll_all", O_START | O_STOP | O_RST | O_LAP, 12, O_RST | O_LAP, O_NONE);
        run("coll_all_rel", O_NONE, 12, O_NONE, O_NONE);
        // stop beats start
        run("coll_ss", O_START | O_STOP, 12, O_STOP, O_NONE);
        run("coll_ss_rel", O_NONE, 12, O_NONE, O_NONE);

        // Direction level rises at edge 6
        run("cd_rise", O_CD, 10, O_NONE, O_CD);

        // Reset mid-press with countDown high, start held across release
        set_raw(O_CD | O_START);
        for (int e = 1; e <= 3; e++) begin
            step();
            check($sformatf("pre_rst e%0d", e), outs(), O_CD);
        end
        reset = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            step();
            check($sformatf("in_rst e%0d", e), outs(), O_NONE);
        end
        reset = 1'b0;
        run("post_rst", O_CD | O_START, 10, O_START, O_CD);

        // Release both: countDown falls at edge 6, no start pulse
        set_raw(O_NONE);
        for (int e = 1; e <= 10; e++) begin
            step();
            exp = (e < 6) ? O_CD : O_NONE;
            check($sformatf("cd_fall e%0d", e), outs(), exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
